// File: rtl/music_pkg.sv
// Tone codes, sequencer states, ROM entry layout and the clock-divider table
// shared by the beat note sequencer and its melody ROM.
package music_pkg;

  localparam int TONE_W      = 6;
  localparam int DIV_ENTRIES = 64;
  localparam int ENT_W       = 7;
  localparam int ENT_START   = 6;
  localparam int ENT_TONE_HI = 5;
  localparam int ENT_TONE_LO = 0;

  localparam logic [5:0] TONE_REST = 6'd0;
  localparam logic [5:0]
    TONE_C3 = 6'd1,  TONE_CS3 = 6'd2,  TONE_D3 = 6'd3,  TONE_DS3 = 6'd4,  TONE_E3 = 6'd5,  TONE_F3 = 6'd6,
    TONE_FS3 = 6'd7, TONE_G3 = 6'd8,   TONE_GS3 = 6'd9, TONE_A3 = 6'd10,  TONE_AS3 = 6'd11, TONE_B3 = 6'd12,
    TONE_C4 = 6'd13, TONE_CS4 = 6'd14, TONE_D4 = 6'd15, TONE_DS4 = 6'd16, TONE_E4 = 6'd17, TONE_F4 = 6'd18,
    TONE_FS4 = 6'd19, TONE_G4 = 6'd20, TONE_GS4 = 6'd21, TONE_A4 = 6'd22, TONE_AS4 = 6'd23, TONE_B4 = 6'd24,
    TONE_C5 = 6'd25, TONE_CS5 = 6'd26, TONE_D5 = 6'd27, TONE_DS5 = 6'd28, TONE_E5 = 6'd29, TONE_F5 = 6'd30,
    TONE_FS5 = 6'd31, TONE_G5 = 6'd32, TONE_GS5 = 6'd33, TONE_A5 = 6'd34, TONE_AS5 = 6'd35, TONE_B5 = 6'd36,
    TONE_C6 = 6'd37, TONE_CS6 = 6'd38, TONE_D6 = 6'd39, TONE_DS6 = 6'd40, TONE_E6 = 6'd41, TONE_F6 = 6'd42,
    TONE_FS6 = 6'd43, TONE_G6 = 6'd44, TONE_GS6 = 6'd45, TONE_A6 = 6'd46, TONE_AS6 = 6'd47, TONE_B6 = 6'd48;

  typedef enum logic [1:0] {
    S_MUTE  = 2'd0,
    S_SOUND = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  typedef struct packed {
    logic              start;
    logic [TONE_W-1:0] tone;
  } rom_entry_t;

  // Octave-3 pitches in micro-hertz (A4 = 440 Hz equal temperament); higher
  // octaves are exact doublings, which keeps the table free of real arithmetic.
  function automatic longint unsigned base_uhz(input int semi);
    case (semi)
      0:       return 64'd130812783;
      1:       return 64'd138591315;
      2:       return 64'd146832384;
      3:       return 64'd155563492;
      4:       return 64'd164813778;
      5:       return 64'd174614116;
      6:       return 64'd184997211;
      7:       return 64'd195997718;
      8:       return 64'd207652349;
      9:       return 64'd220000000;
      10:      return 64'd233081881;
      default: return 64'd246941651;
    endcase
  endfunction

  // round(clk_freq / f) for tone codes 1..48; everything else is silence.
  function automatic int unsigned tone_div(input int unsigned clk_freq, input int code);
    longint unsigned f;
    longint unsigned num;
    if (code < 1 || code > 48) return 32'd0;
    f   = base_uhz((code - 1) % 12) << ((code - 1) / 12);
    num = 64'(clk_freq) * 64'd1000000;
    return 32'((num + (f >> 1)) / f);
  endfunction

endpackage

// File: rtl/melody_rom.sv
// Synchronous-read song ROM, 4096 x {start, tone}; beats at or above LEN read
// as rest.
module melody_rom
  import music_pkg::*;
#(
  parameter int LEN = 4095
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [11:0]      addr,
  output logic [ENT_W-1:0] data
);

  localparam logic [12:0] LEN_L = 13'(LEN);

  function automatic logic [ENT_W-1:0] song(input logic [11:0] a);
    case (a)
      12'd0:    song = {1'b1, TONE_A4};
      12'd1:    song = {1'b0, TONE_A4};
      12'd2:    song = {1'b1, TONE_B4};
      12'd3:    song = {1'b1, TONE_CS5};
      12'd4:    song = {1'b1, TONE_E4};
      12'd5:    song = {1'b1, TONE_A3};
      12'd6:    song = {1'b0, TONE_A3};
      12'd7:    song = {1'b1, TONE_A3};
      12'd8:    song = {1'b1, TONE_REST};
      12'd9:    song = {1'b0, TONE_E4};
      12'd10:   song = {1'b1, TONE_E4};
      12'd11:   song = {1'b0, TONE_E4};
      12'd12:   song = {1'b1, TONE_E4};
      12'd4094: song = {1'b1, TONE_C4};
      default:  song = '0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                data <= '0;
    else if ({1'b0, addr} >= LEN_L) data <= '0;
    else                         data <= song(addr);
  end

endmodule

// File: rtl/beat_note_sequencer.sv
// Turns the player's beat index into a note divider for the square-wave
// generator, with re-strike articulation gaps. OCTAVE_SHIFT_EN adds an octave input.
//
// state   | meaning
// S_MUTE  | silent, tone = 0 (paused, rest or reset)
// S_SOUND | note_div = divider of current tone
// S_GAP   | re-strike silence, tone held, gap counter running down
module beat_note_sequencer
  import music_pkg::*;
#(
  parameter int LEN        = 4095,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int GAP_CYCLES = 5_000_000,
  parameter int DIV_W      = 22
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             play_pause,
  input  logic [11:0]      ibeat,
`ifdef OCTAVE_SHIFT_EN
  input  logic [1:0]       octave,
`endif
  output logic [DIV_W-1:0] note_div,
  output logic [5:0]       tone,
  output logic             onset
);

  localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  logic [DIV_W-1:0] div_tab [DIV_ENTRIES];
  for (genvar g = 0; g < DIV_ENTRIES; g++) begin : g_div
    assign div_tab[g] = DIV_W'(tone_div(CLK_FREQ, g));
  end

  logic [ENT_W-1:0]  rom_q;
  logic [11:0]       ibeat_prev;
  logic              new_beat_d;
  logic              rom_vld;
  logic              e_start;
  logic [TONE_W-1:0] e_tone;

  state_t            state_q, state_nx;
  logic [TONE_W-1:0] tone_nx;
  logic [CNT_W-1:0]  cnt_q, cnt_nx;
  logic              retrig_q, retrig_nx;
  logic              onset_nx;
  logic [DIV_W-1:0]  div_nx;

  melody_rom #(.LEN(LEN)) u_rom (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (ibeat),
    .data    (rom_q)
  );

  assign e_start = rom_q[ENT_START];
  assign e_tone  = rom_q[ENT_TONE_HI:ENT_TONE_LO];

  // rom_vld keeps the reset-time retrigger from evaluating a not-yet-read entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ibeat_prev <= '0;
      new_beat_d <= 1'b0;
      rom_vld    <= 1'b0;
    end else begin
      ibeat_prev <= ibeat;
      new_beat_d <= (ibeat != ibeat_prev);
      rom_vld    <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_MUTE;
      tone     <= TONE_REST;
      cnt_q    <= '0;
      retrig_q <= 1'b1;
      note_div <= '0;
      onset    <= 1'b0;
    end else begin
      state_q  <= state_nx;
      tone     <= tone_nx;
      cnt_q    <= cnt_nx;
      retrig_q <= retrig_nx;
      note_div <= div_nx;
      onset    <= onset_nx;
    end
  end

  always_comb begin
    state_nx  = state_q;
    tone_nx   = tone;
    cnt_nx    = cnt_q;
    retrig_nx = retrig_q;
    onset_nx  = 1'b0;
    if (!play_pause) begin
      state_nx  = S_MUTE;
      tone_nx   = TONE_REST;
      cnt_nx    = '0;
      retrig_nx = 1'b1;
    end else if (new_beat_d || (retrig_q && rom_vld)) begin
      retrig_nx = 1'b0;
      if (e_tone == TONE_REST) begin
        state_nx = S_MUTE;
        tone_nx  = TONE_REST;
        cnt_nx   = '0;
      end else if (!retrig_q && e_start && e_tone == tone && state_q == S_SOUND) begin
        state_nx = S_GAP;
        cnt_nx   = GAP_LOAD;
      end else if (retrig_q || e_start || e_tone != tone) begin
        state_nx = S_SOUND;
        tone_nx  = e_tone;
        cnt_nx   = '0;
        onset_nx = 1'b1;
      end
    end
    // A held (same-tone, no-start) beat during the gap lets the countdown continue.
    if (play_pause && state_q == S_GAP && state_nx == S_GAP && cnt_nx == cnt_q) begin
      if (cnt_q == '0) begin
        state_nx = S_SOUND;
        onset_nx = 1'b1;
      end else begin
        cnt_nx = cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    div_nx = '0;
    if (state_nx == S_SOUND) begin
`ifdef OCTAVE_SHIFT_EN
      case (octave)
        2'b01:   div_nx = div_tab[tone_nx] >> 1;
        2'b10:   div_nx = div_tab[tone_nx] << 1;
        default: div_nx = div_tab[tone_nx];
      endcase
`else
      div_nx = div_tab[tone_nx];
`endif
    end
  end

endmodule
